bram_stream_fifo_ctrl: RTL and testbench

- Controller that turns the on-chip true dual-port write-first BRAM into a valid/ready streaming FIFO.
- Sits directly upstream of the BRAM and drives both of its ports:
  - port A is write-only;
  - port B is read-only, with its 1-cycle registered read data returned to this block.
- A single output holding stage gives first-word-fall-through behaviour to the downstream consumer.
- The BRAM itself is instantiated alongside this block by the parent; it is not part of this block.

---
 rtl/bram_stream_fifo_ctrl.sv | 119 +++++++++++
 tb/tb_bram_stream_fifo_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_fifo_ctrl.sv
// Streaming FIFO controller wrapped around an external dual-port BRAM.
// Port A writes, port B reads, with a first-word-fall-through output stage.
module bram_stream_fifo_ctrl #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic                     flush_i,
  input  logic [RAM_WIDTH-1:0]     s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic [RAM_WIDTH-1:0]     m_data_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [RAM_ADDR_BITS:0]   level_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     bram_en_a_o,
  output logic                     bram_we_a_o,
  output logic [RAM_ADDR_BITS-1:0] bram_addr_a_o,
  output logic [RAM_WIDTH-1:0]     bram_data_a_o,
  output logic                     bram_en_b_o,
  output logic                     bram_we_b_o,
  output logic [RAM_ADDR_BITS-1:0] bram_addr_b_o,
  output logic [RAM_WIDTH-1:0]     bram_data_b_o,
  input  logic [RAM_WIDTH-1:0]     bram_data_b_i
);

  localparam int AW = RAM_ADDR_BITS;
  localparam int CW = RAM_ADDR_BITS + 1;

  localparam logic [CW-1:0] DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] mem_cnt;
  logic [CW-1:0] mem_cnt_nxt;
  logic [CW-1:0] level_q;
  logic [CW-1:0] level_nxt;
  logic          m_valid_q;
  logic          wr_fire;
  logic          rd_issue;
  logic          m_fire;

  assign s_ready_o = (mem_cnt < DEPTH) && !flush_i;
  assign wr_fire   = s_valid_i && s_ready_o;
  assign m_fire    = m_valid_q && m_ready_i;

  // Only refill the output stage when it is empty or being drained.
  assign rd_issue = (mem_cnt != '0)
                 && (!m_valid_q || m_ready_i)
                 && !flush_i;

  assign bram_en_a_o   = wr_fire;
  assign bram_we_a_o   = wr_fire;
  assign bram_addr_a_o = wr_ptr;
  assign bram_data_a_o = s_data_i;

  assign bram_en_b_o   = rd_issue;
  assign bram_we_b_o   = 1'b0;
  assign bram_addr_b_o = rd_ptr;
  assign bram_data_b_o = '0;

  // Port B's output register doubles as the holding stage.
  assign m_data_o  = bram_data_b_i;
  assign m_valid_o = m_valid_q;

  assign level_o = level_q;
  assign full_o  = !s_ready_o;
  assign empty_o = (level_q == '0);

  always_comb begin
    mem_cnt_nxt = mem_cnt;
    case ({wr_fire, rd_issue})
      2'b10:   mem_cnt_nxt = mem_cnt + CNT_ONE;
      2'b01:   mem_cnt_nxt = mem_cnt - CNT_ONE;
      default: mem_cnt_nxt = mem_cnt;
    endcase
  end

  always_comb begin
    level_nxt = level_q;
    case ({wr_fire, m_fire})
      2'b10:   level_nxt = level_q + CNT_ONE;
      2'b01:   level_nxt = level_q - CNT_ONE;
      default: level_nxt = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      level_q   <= '0;
      m_valid_q <= 1'b0;
    end else if (flush_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      level_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      mem_cnt   <= mem_cnt_nxt;
      level_q   <= level_nxt;
      m_valid_q <= rd_issue || (m_valid_q && !m_ready_i);
    end
  end

endmodule

// File: tb/tb_bram_stream_fifo_ctrl.sv
// Directed bench for bram_stream_fifo_ctrl with a 4-deep BRAM model.
// Each task drives one scenario and checks against hand-derived values.
module tb_bram_stream_fifo_ctrl;

  localparam int W  = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          en_a;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [W-1:0]  data_a;
  logic          en_b;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [W-1:0]  data_b_o;
  logic [W-1:0]  data_b_i;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem [4];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en_a && we_a) mem[addr_a] <= data_a;
    if (en_b) data_b_i <= mem[addr_b];
  end

  bram_stream_fifo_ctrl #(
    .RAM_WIDTH(W),
    .RAM_ADDR_BITS(AW)
  ) dut (
    .clk_i(clk),
    .arstn_i(arstn),
    .flush_i(flush),
    .s_data_i(s_data),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .m_data_o(m_data),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready),
    .level_o(level),
    .full_o(full),
    .empty_o(empty),
    .bram_en_a_o(en_a),
    .bram_we_a_o(we_a),
    .bram_addr_a_o(addr_a),
    .bram_data_a_o(data_a),
    .bram_en_b_o(en_b),
    .bram_we_b_o(we_b),
    .bram_addr_b_o(addr_b),
    .bram_data_b_o(data_b_o),
    .bram_data_b_i(data_b_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || level !== 3'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b level=%0d empty=%b exp 0/0/1",
               m_valid, level, empty);
    end
    checks++;
    if (en_b !== 1'b0 || addr_a !== 2'd0 || addr_b !== 2'd0) begin
      errors++;
      $display("FAIL reset_ptrs: en_b=%b addr_a=%0d addr_b=%0d exp 0/0/0",
               en_b, addr_a, addr_b);
    end
    arstn = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: s_ready=%b full=%b exp 1/0", s_ready, full);
    end
    checks++;
    if (we_b !== 1'b0 || data_b_o !== 8'h00) begin
      errors++;
      $display("FAIL portb_const: we_b=%b data_b=%h exp 0/00", we_b, data_b_o);
    end
    tick();
  endtask

  task automatic test_basic();
    logic exp_v;
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_valid = (i < 3);
      s_data  = 8'hA1 + 8'(i);
      @(negedge clk);
      if (i < 3) begin
        checks++;
        if (en_a !== 1'b1 || we_a !== 1'b1 || addr_a !== 2'(i) ||
            data_a !== 8'hA1 + 8'(i)) begin
          errors++;
          $display("FAIL basic_porta cyc %0d: en=%b we=%b addr=%0d data=%h",
                   i, en_a, we_a, addr_a, data_a);
        end
      end
      exp_v = (i >= 2 && i <= 4);
      checks++;
      if (m_valid !== exp_v) begin
        errors++;
        $display("FAIL basic_valid cyc %0d: got %b exp %b", i, m_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (m_data !== 8'hA1 + 8'(i - 2)) begin
          errors++;
          $display("FAIL basic_data cyc %0d: got %h exp %h",
                   i, m_data, 8'hA1 + 8'(i - 2));
        end
      end
      tick();
    end
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (empty !== 1'b1 || level !== 3'd0) begin
      errors++;
      $display("FAIL basic_empty: empty=%b level=%0d exp 1/0", empty, level);
    end
    tick();
  endtask

  task automatic test_full();
    int   n_out;
    logic acc;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = 8'h10 + 8'(i);
      @(negedge clk);
      checks++;
      if (s_ready !== (i < 5)) begin
        errors++;
        $display("FAIL full_ready word %0d: got %b exp %b", i, s_ready, (i < 5));
      end
      if (i < 5) tick();
    end
    checks++;
    if (level !== 3'd5 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_level: level=%0d full=%b exp 5/1", level, full);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h10) begin
      errors++;
      $display("FAIL full_head: valid=%b data=%h exp 1/10", m_valid, m_data);
    end
    tick();
    m_ready = 1'b1;
    n_out = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      if (m_valid) begin
        checks++;
        if (m_data !== 8'h10 + 8'(n_out)) begin
          errors++;
          $display("FAIL full_drain idx %0d: got %h exp %h",
                   n_out, m_data, 8'h10 + 8'(n_out));
        end
        n_out++;
      end
      tick();
      if (acc) s_valid = 1'b0;
    end
    checks++;
    if (n_out != 6 || empty !== 1'b1) begin
      errors++;
      $display("FAIL full_count: got %0d words empty=%b exp 6/1", n_out, empty);
    end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h55;
    tick();
    s_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'h55 || en_b !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc %0d: valid=%b data=%h en_b=%b exp 1/55/0",
                 i, m_valid, m_data, en_b);
      end
      tick();
    end
    m_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b empty=%b exp 0/1", m_valid, empty);
    end
    tick();
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 8'hC0 + 8'(i);
      tick();
    end
    s_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre_level: got %0d exp 3", level);
    end
    tick();
    s_valid = 1'b1;
    s_data  = 8'hEE;
    flush   = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || en_a !== 1'b0 || en_b !== 1'b0) begin
      errors++;
      $display("FAIL flush_block: s_ready=%b en_a=%b en_b=%b exp 0/0/0",
               s_ready, en_a, en_b);
    end
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (level !== 3'd0 || m_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: level=%0d valid=%b empty=%b exp 0/0/1",
               level, m_valid, empty);
    end
    tick();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h77;
    tick();
    s_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h77) begin
      errors++;
      $display("FAIL flush_next: valid=%b data=%h exp 1/77", m_valid, m_data);
    end
    tick();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL flush_after: valid=%b empty=%b exp 0/1", m_valid, empty);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] pat;
    int n_in;
    int n_out;
    int n_iss;
    pat   = 32'hB53C96E1;
    n_in  = 0;
    n_out = 0;
    n_iss = 0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (n_out == 20) break;
      s_valid = (n_in < 20);
      s_data  = 8'h30 + 8'(n_in);
      m_ready = pat[c % 32];
      @(negedge clk);
      if (s_valid && s_ready) begin
        checks++;
        if (addr_a !== 2'(n_in)) begin
          errors++;
          $display("FAIL wrap_wr_addr word %0d: got %0d exp %0d",
                   n_in, addr_a, 2'(n_in));
        end
        n_in++;
      end
      if (en_b) begin
        checks++;
        if (addr_b !== 2'(n_iss)) begin
          errors++;
          $display("FAIL wrap_rd_addr word %0d: got %0d exp %0d",
                   n_iss, addr_b, 2'(n_iss));
        end
        n_iss++;
      end
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 8'h30 + 8'(n_out)) begin
          errors++;
          $display("FAIL wrap_data idx %0d: got %h exp %h",
                   n_out, m_data, 8'h30 + 8'(n_out));
        end
        n_out++;
      end
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    checks++;
    if (n_out != 20) begin
      errors++;
      $display("FAIL wrap_count: got %0d words exp 20", n_out);
    end
    tick();
  endtask

  task automatic test_async_reset();
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 8'hD0 + 8'(i);
      tick();
    end
    s_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (level !== 3'd3 || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: level=%0d valid=%b exp 3/1", level, m_valid);
    end
    #2;
    arstn = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || level !== 3'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL arst_clear: valid=%b level=%0d empty=%b exp 0/0/1",
               m_valid, level, empty);
    end
    checks++;
    if (addr_a !== 2'd0 || addr_b !== 2'd0) begin
      errors++;
      $display("FAIL arst_ptrs: addr_a=%0d addr_b=%0d exp 0/0", addr_a, addr_b);
    end
    @(negedge clk);
    arstn = 1'b1;
    tick();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h99;
    tick();
    s_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h99) begin
      errors++;
      $display("FAIL arst_next: valid=%b data=%h exp 1/99", m_valid, m_data);
    end
    tick();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL arst_after: valid=%b empty=%b exp 0/1", m_valid, empty);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_backpressure();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
